// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - RC/servo PWM pulse decoder producing speed commands with loss-of-signal failsafe
module pwm_capture #(
    parameter int          PRESCALE   = 50,
    parameter int          FILTER_LEN = 4,
    parameter int          MIN_WIDTH  = 1000,
    parameter int          SPAN_LOG2  = 10,
    parameter int          REJECT_LO  = 800,
    parameter int          REJECT_HI  = 2200,
    parameter int          TIMEOUT    = 25000,
    parameter logic [15:0] FAILSAFE   = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    input  logic        busy,
    output logic [15:0] speed_out,
    output logic        speed_oe,
    output logic [15:0] pulse_width,
    output logic        signal_ok,
    output logic        pulse_err
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FL_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [15:0] LO16   = 16'(REJECT_LO);
    localparam logic [15:0] HI16   = 16'(REJECT_HI);
    localparam logic [15:0] MIN16  = 16'(MIN_WIDTH);
    localparam logic [15:0] FULL16 = 16'(MIN_WIDTH + 2**SPAN_LOG2);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } state_t;

    state_t state, state_next;

    logic            s1, s2;
    logic [1:0]      prime;
    logic            filt, filt_d;
    logic [FL_W-1:0] flt_cnt;
    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [15:0]     width;
    logic [15:0]     width_inc;
    logic [TO_W-1:0] gap;
    logic            rise, fall;
    logic            width_clr, measure_done;
    logic            valid;
    logic [15:0]     speed_calc;
    logic [15:0]     diff;
    logic [15:0]     pend_val;
    logic            pend_flag;
    logic            handoff, timeout_hit;

    // Synchronizer and primed flag: prime marks when s2 reflects the real pin after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prime <= 2'b00;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            prime <= {prime[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            flt_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (s2 != filt) begin
                if (flt_cnt == FL_W'(FILTER_LEN - 1)) begin
                    filt    <= s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        width_clr    = 1'b0;
        measure_done = 1'b0;
        case (state)
            WAIT_LOW: begin
                // Leave only once the pin is genuinely and stably low, so a pulse in flight at reset is skipped
                if (prime[1] && !filt && !s2 && (flt_cnt == '0)) begin
                    state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    width_clr  = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    measure_done = 1'b1;
                    state_next   = WAIT_RISE;
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    // The tick in the falling-edge cycle is included so a pulse of exactly k ticks reads k
    assign width_inc = (tick && (width != 16'hFFFF)) ? width + 16'd1 : width;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width <= '0;
        end else if (width_clr) begin
            width <= '0;
        end else if (state == HIGH) begin
            width <= width_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if (rise) begin
            gap <= '0;
        end else if (tick && (gap != TO_W'(TIMEOUT))) begin
            gap <= gap + 1'b1;
        end
    end

    assign timeout_hit = tick && !rise && (gap == TO_W'(TIMEOUT - 1));

    always_comb begin
        valid      = (width_inc >= LO16) && (width_inc <= HI16);
        diff       = width_inc - MIN16;
        speed_calc = diff << (16 - SPAN_LOG2);
        if (width_inc <= MIN16) begin
            speed_calc = 16'h0000;
        end else if (width_inc >= FULL16) begin
            speed_calc = 16'hFFFF;
        end
    end

    assign handoff = pend_flag && !busy;

    // Later assignments take priority: a fresh result overrides failsafe and handoff clearing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_out   <= '0;
            speed_oe    <= 1'b0;
            pulse_width <= '0;
            signal_ok   <= 1'b0;
            pulse_err   <= 1'b0;
            pend_val    <= '0;
            pend_flag   <= 1'b0;
        end else begin
            speed_oe  <= 1'b0;
            pulse_err <= 1'b0;
            if (handoff) begin
                speed_out <= pend_val;
                speed_oe  <= 1'b1;
                pend_flag <= 1'b0;
            end
            if (timeout_hit && signal_ok) begin
                signal_ok <= 1'b0;
                pend_val  <= FAILSAFE;
                pend_flag <= 1'b1;
            end
            if (measure_done) begin
                pulse_width <= width_inc;
                pulse_err   <= !valid;
                if (valid) begin
                    pend_val  <= speed_calc;
                    pend_flag <= 1'b1;
                    signal_ok <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;

    localparam int PS = 2;
    localparam int TO = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic        busy = 1'b0;
    logic [15:0] speed_out;
    logic        speed_oe;
    logic [15:0] pulse_width;
    logic        signal_ok;
    logic        pulse_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [15:0] exp_q[$];

    pwm_capture #(
        .PRESCALE  (PS),
        .FILTER_LEN(4),
        .MIN_WIDTH (1000),
        .SPAN_LOG2 (10),
        .REJECT_LO (800),
        .REJECT_HI (2200),
        .TIMEOUT   (TO),
        .FAILSAFE  (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .busy       (busy),
        .speed_out  (speed_out),
        .speed_oe   (speed_oe),
        .pulse_width(pulse_width),
        .signal_ok  (signal_ok),
        .pulse_err  (pulse_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * PS) @(negedge clk);
    endtask

    task automatic pulse(input int w, input int low);
        pwm_in = 1'b1;
        ticks(w);
        pwm_in = 1'b0;
        ticks(low);
    endtask

    always @(negedge clk) begin
        if (!rst && speed_oe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual=%0h required=none", speed_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (speed_out !== e) begin
                    errors++;
                    $display("FAIL speed_out actual=%0h required=%0h", speed_out, e);
                end
            end
        end
        if (!rst && pulse_err) err_pulses++;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_speed_out", speed_out, 16'h0);
        check("rst_speed_oe", speed_oe, 1'b0);
        check("rst_pulse_width", pulse_width, 16'h0);
        check("rst_signal_ok", signal_ok, 1'b0);
        check("rst_pulse_err", pulse_err, 1'b0);
        rst = 1'b0;
        ticks(50);
        check("idle_signal_ok", signal_ok, 1'b0);

        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(16'h7D00);
            pulse(1500, 200);
            check("w1500_width", pulse_width, 16'd1500);
            check("w1500_ok", signal_ok, 1'b1);
        end

        exp_q.push_back(16'h0000);
        pulse(900, 200);
        check("w900_width", pulse_width, 16'd900);
        exp_q.push_back(16'hFFFF);
        pulse(2100, 200);
        check("w2100_width", pulse_width, 16'd2100);
        exp_q.push_back(16'hFFC0);
        pulse(2023, 200);
        check("w2023_width", pulse_width, 16'd2023);

        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        ticks(100);
        check("glitch_width", pulse_width, 16'd2023);
        pulse(300, 200);
        check("w300_width", pulse_width, 16'd300);
        check("w300_ok", signal_ok, 1'b1);

        busy = 1'b1;
        pulse(1200, 200);
        pulse(1400, 200);
        pulse(1600, 200);
        check("busy_width", pulse_width, 16'd1600);
        exp_q.push_back(16'h9600);
        busy = 1'b0;
        ticks(10);

        ticks(1000);
        check("pre_timeout_ok", signal_ok, 1'b1);
        exp_q.push_back(16'h0000);
        ticks(400);
        check("timeout_ok", signal_ok, 1'b0);
        exp_q.push_back(16'h7D00);
        pulse(1500, 200);
        check("resume_ok", signal_ok, 1'b1);
        check("resume_width", pulse_width, 16'd1500);

        busy = 1'b1;
        pulse(1200, 200);
        pwm_in = 1'b1;
        ticks(500);
        rst = 1'b1;
        #1;
        check("mid_rst_speed_out", speed_out, 16'h0);
        check("mid_rst_pulse_width", pulse_width, 16'h0);
        check("mid_rst_signal_ok", signal_ok, 1'b0);
        check("mid_rst_speed_oe", speed_oe, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        ticks(1000);
        pwm_in = 1'b0;
        ticks(200);
        check("partial_ok", signal_ok, 1'b0);
        check("partial_width", pulse_width, 16'h0);
        exp_q.push_back(16'h7D00);
        pulse(1500, 200);
        check("post_rst_ok", signal_ok, 1'b1);
        check("post_rst_width", pulse_width, 16'd1500);

        ticks(50);
        check("queue_drained", exp_q.size(), 32'd0);
        check("pulse_err_count", err_pulses, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
